acq_peak_search: RTL
====================

# acq_peak_search

Parametrised acquisition search engine for the B1I receiver. It sequences a Doppler × code-phase search by issuing one Doppler-bin request at a time to an external correlator. It then consumes that bin's correlation magnitudes as a stream and tracks the global peak and the accumulated energy. At the end it computes the noise mean with an iterative divider and makes a threshold-ratio detection decision. It replaces the monolithic array-based acquisition core, with streaming inputs, configurable search grid, abort and backpressure.

## Interface
- MAG_W, 32, correlation magnitude width (unsigned)
- PHASE_W, 11, code-phase index width
- NUM_PHASES, 2046, magnitudes per Doppler bin
- BIN_W, 8, Doppler-bin index width
- NUM_BINS, 41, Doppler bins per search
- DOPP_START, -10000, first bin frequency in Hz (signed 16-bit)
- DOPP_STEP, 500, bin spacing in Hz
- EXCL, 5, circular phase exclusion half-width (second-peak option)
- ACC_W, 56, energy accumulator width; must be ≥ MAG_W + clog2(NUM_BINS·NUM_PHASES)
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- start  in  1  begin a search; ignored unless idle
- abort  in  1  cancel the search in progress
- thresh  in  16  detection ratio, unsigned Q8.8
- bin_req_valid  out  1  Doppler-bin request valid
- bin_req_ready  in  1  correlator accepts the request
- bin_req_idx  out  BIN_W  requested bin index
- bin_req_freq  out  16  requested Doppler in Hz, signed
- mag_valid  in  1  magnitude valid
- mag_ready  out  1  engine accepts the magnitude
- mag_data  in  MAG_W  magnitude, in phase order 0..NUM_PHASES-1
- busy  out  1  search in progress
- done  out  1  one-cycle completion pulse
- detected, code_phase[PHASE_W], doppler_bin[BIN_W], doppler_freq[16], peak[MAG_W], noise_mean[MAG_W], second_peak[MAG_W]  out  result registers

## Operation
- **States:** IDLE, REQ, COLLECT, NEXT, DIV, DONE.
- **IDLE:**
  - On start: clear peak, accumulator, bin counter and phase counter; set the frequency register to DOPP_START; go to REQ.
- **REQ:**
  - bin_req_valid=1.
  - On bin_req_valid&bin_req_ready, go to COLLECT.
- **COLLECT:**
  - mag_ready=1.
  - Each handshake adds mag_data to the accumulator and increments the phase counter.
  - If mag_data > running peak (strictly greater), record the magnitude, phase and bin. Ties keep the earliest sample.
  - After sample NUM_PHASES-1, go to NEXT.
- **NEXT:**
  - If bin == NUM_BINS-1, go to DIV.
  - Otherwise increment the bin, add DOPP_STEP to the frequency register, clear the phase counter, and go to REQ.
- **DIV:**
  - Restoring divider computes (acc − peak) / (NUM_BINS·NUM_PHASES − 1), truncated.
  - One quotient bit per cycle, exactly ACC_W cycles. The quotient fits in MAG_W.
- **DONE:**
  - Load all result registers.
  - detected = ({peak,8'b0} > thresh·noise_mean), compared at MAG_W+16 bits.
  - Pulse done; return to IDLE.
- **Abort:** in any non-IDLE state, abort forces IDLE on the next edge. done is not pulsed and the result registers keep their prior values. Abort takes priority over any handshake in the same cycle.
- busy = (state != IDLE).
- Result registers change only in DONE.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including bin_req_valid, mag_ready, busy, done and every result register.
  - bin_req_freq = DOPP_START.
- Latency after start:
  - start seen → bin_req_valid rises on the next edge.
  - Last magnitude accepted → NEXT (1 cycle) → DIV (ACC_W cycles) → done pulses the following cycle.
- bin_req_idx and bin_req_freq are stable while bin_req_valid is high.
- mag_ready is low outside COLLECT. Magnitudes presented then are not consumed.
- start while busy: ignored.
- start in the same cycle as done: ignored. A new search needs start while in IDLE.

## Configuration
- **ACQ_SECOND_PEAK_EN defined:** second_peak tracks the largest magnitude whose phase lies circularly more than EXCL from the peak phase. Circular distance is min(|a−b|, NUM_PHASES−|a−b|). Update per accepted sample m at phase p:
  - If m > peak: second = old peak when the old peak phase is far from p; otherwise second = second when the second phase is far from p, else 0.
  - Else if the peak phase is far from p and m > second: second = m and its phase is recorded.
- **Undefined:** no second-peak logic is built and second_peak is tied to 0.

## Test plan
Bench parameters for every scenario: NUM_PHASES=16, NUM_BINS=3, EXCL=1, DOPP_START=-10000, DOPP_STEP=500, thresh=0x0180.
- **Single peak:** all magnitudes 10 except bin1 phase5 = 200 → detected=1, code_phase=5, doppler_bin=1, doppler_freq=-9500, peak=200, noise_mean=10. done pulses ACC_W+1 cycles after the last accept.
- **Flat input:** all magnitudes 10 → peak=10 at bin0 phase0, noise_mean=10, detected=0.
- **Second peak (macro on):** bin0 phase8 = 150, bin2 phase0 = 200, all others 10 → peak=200, second_peak=150, noise_mean=12, code_phase=0, doppler_bin=2.
- **Backpressure:**
  - bin_req_ready held low 5 cycles per request → bin_req_idx/bin_req_freq hold steady; results match the single-peak case.
  - mag_valid randomly gapped → same results as without gaps.
- **Abort:** abort asserted mid-COLLECT of bin1 → IDLE next cycle, busy=0, no done pulse, results unchanged. A subsequent start completes a full search normally.
- **Reset mid-search:** rst_n asserted during DIV → all outputs 0 immediately. A start after reset release runs a complete search.

Source files
------------

// File: rtl/acq_peak_search.sv
// Acquisition search: requests Doppler bins, streams correlation magnitudes, tracks peak and energy,
// then derives noise mean with a restoring divider and makes a ratio detection. ACQ_SECOND_PEAK_EN adds second-peak tracking.
module acq_peak_search #(
  parameter int                 MAG_W      = 32,
  parameter int                 PHASE_W    = 11,
  parameter int                 NUM_PHASES = 2046,
  parameter int                 BIN_W      = 8,
  parameter int                 NUM_BINS   = 41,
  parameter logic signed [15:0] DOPP_START = -16'sd10000,
  parameter int                 DOPP_STEP  = 500,
  parameter int                 EXCL       = 5,
  parameter int                 ACC_W      = 56
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [15:0]        thresh,
  output logic               bin_req_valid,
  input  logic               bin_req_ready,
  output logic [BIN_W-1:0]   bin_req_idx,
  output logic [15:0]        bin_req_freq,
  input  logic               mag_valid,
  output logic               mag_ready,
  input  logic [MAG_W-1:0]   mag_data,
  output logic               busy,
  output logic               done,
  output logic               detected,
  output logic [PHASE_W-1:0] code_phase,
  output logic [BIN_W-1:0]   doppler_bin,
  output logic [15:0]        doppler_freq,
  output logic [MAG_W-1:0]   peak,
  output logic [MAG_W-1:0]   noise_mean,
  output logic [MAG_W-1:0]   second_peak
);

  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [ACC_W-1:0] DIVISOR = ACC_W'(NUM_BINS * NUM_PHASES - 1);

  typedef enum logic [2:0] {IDLE, REQ, COLLECT, NEXT, DIV, DONE} state_t;
  state_t state;

  logic [ACC_W-1:0]   acc;
  logic [MAG_W-1:0]   run_peak;
  logic [PHASE_W-1:0] run_phase;
  logic [BIN_W-1:0]   run_bin;
  logic [15:0]        run_freq;
  logic [PHASE_W-1:0] phase_cnt;
  logic [ACC_W-1:0]   rem;
  logic [ACC_W-1:0]   quo;
  logic [CNT_W-1:0]   div_cnt;

  logic [ACC_W:0]       trial;
  logic                 trial_ge;
  logic [ACC_W-1:0]     rem_n;
  logic [ACC_W-1:0]     quo_n;
  logic [MAG_W-1:0]     noise_n;
  logic [MAG_W+15:0]    peak_sh;
  logic [MAG_W+15:0]    thr_prod;
  logic                 mag_last;

  // Circular phase distance strictly greater than the exclusion half-width.
  function automatic logic is_far(input logic [PHASE_W-1:0] a, input logic [PHASE_W-1:0] b);
    int d;
    d = (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
    if (NUM_PHASES - d < d) d = NUM_PHASES - d;
    return d > EXCL;
  endfunction

  // One restoring-division step; the final step's quotient feeds the result load directly.
  always_comb begin
    trial    = {rem, quo[ACC_W-1]};
    trial_ge = (trial >= {1'b0, DIVISOR});
    rem_n    = trial_ge ? ACC_W'(trial - {1'b0, DIVISOR}) : trial[ACC_W-1:0];
    quo_n    = {quo[ACC_W-2:0], trial_ge};
    noise_n  = quo_n[MAG_W-1:0];
    peak_sh  = {8'b0, run_peak, 8'b0};
    thr_prod = {{MAG_W{1'b0}}, thresh} * {16'b0, noise_n};
    mag_last = (phase_cnt == PHASE_W'(NUM_PHASES - 1));
  end

`ifdef ACQ_SECOND_PEAK_EN
  logic [MAG_W-1:0]   sec;
  logic [PHASE_W-1:0] sec_phase;
`else
  assign second_peak = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      bin_req_valid <= 1'b0;
      mag_ready     <= 1'b0;
      bin_req_idx   <= '0;
      bin_req_freq  <= DOPP_START;
      phase_cnt     <= '0;
      acc           <= '0;
      run_peak      <= '0;
      run_phase     <= '0;
      run_bin       <= '0;
      run_freq      <= '0;
      rem           <= '0;
      quo           <= '0;
      div_cnt       <= '0;
      detected      <= 1'b0;
      code_phase    <= '0;
      doppler_bin   <= '0;
      doppler_freq  <= '0;
      peak          <= '0;
      noise_mean    <= '0;
`ifdef ACQ_SECOND_PEAK_EN
      sec           <= '0;
      sec_phase     <= '0;
      second_peak   <= '0;
`endif
    end else if (abort && state != IDLE) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      bin_req_valid <= 1'b0;
      mag_ready     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc           <= '0;
          run_peak      <= '0;
          run_phase     <= '0;
          run_bin       <= '0;
          run_freq      <= '0;
          phase_cnt     <= '0;
          bin_req_idx   <= '0;
          bin_req_freq  <= DOPP_START;
`ifdef ACQ_SECOND_PEAK_EN
          sec           <= '0;
          sec_phase     <= '0;
`endif
          busy          <= 1'b1;
          bin_req_valid <= 1'b1;
          state         <= REQ;
        end
        REQ: if (bin_req_ready) begin
          bin_req_valid <= 1'b0;
          mag_ready     <= 1'b1;
          state         <= COLLECT;
        end
        COLLECT: if (mag_valid) begin
          acc <= acc + ACC_W'(mag_data);
          if (mag_data > run_peak) begin
            run_peak  <= mag_data;
            run_phase <= phase_cnt;
            run_bin   <= bin_req_idx;
            run_freq  <= bin_req_freq;
          end
`ifdef ACQ_SECOND_PEAK_EN
          if (mag_data > run_peak) begin
            if (is_far(run_phase, phase_cnt)) begin
              sec       <= run_peak;
              sec_phase <= run_phase;
            end else if (!is_far(sec_phase, phase_cnt)) begin
              sec <= '0;
            end
          end else if (is_far(run_phase, phase_cnt) && mag_data > sec) begin
            sec       <= mag_data;
            sec_phase <= phase_cnt;
          end
`endif
          phase_cnt <= phase_cnt + PHASE_W'(1);
          if (mag_last) begin
            mag_ready <= 1'b0;
            state     <= NEXT;
          end
        end
        NEXT: if (bin_req_idx == BIN_W'(NUM_BINS - 1)) begin
          rem     <= '0;
          quo     <= acc - ACC_W'(run_peak);
          div_cnt <= '0;
          state   <= DIV;
        end else begin
          bin_req_idx   <= bin_req_idx + BIN_W'(1);
          bin_req_freq  <= bin_req_freq + 16'(DOPP_STEP);
          phase_cnt     <= '0;
          bin_req_valid <= 1'b1;
          state         <= REQ;
        end
        DIV: begin
          rem     <= rem_n;
          quo     <= quo_n;
          div_cnt <= div_cnt + CNT_W'(1);
          if (div_cnt == CNT_W'(ACC_W - 1)) begin
            detected     <= (peak_sh > thr_prod);
            code_phase   <= run_phase;
            doppler_bin  <= run_bin;
            doppler_freq <= run_freq;
            peak         <= run_peak;
            noise_mean   <= noise_n;
`ifdef ACQ_SECOND_PEAK_EN
            second_peak  <= sec;
`endif
            done         <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
